// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART transmitter and receiver.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Integer bit period in system clocks (truncating division).
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronises rx, validates the start bit at half period,
// samples each bit mid-period and publishes the byte only on a valid stop bit.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data_out
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB) + 1;
  localparam int BW  = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_WIDTH - 1);

  rx_state_t             state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [BW-1:0]         bit_idx, idx_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  rx_meta, rx_sync;

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver state, counters and the published byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_data_out <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= idx_next;
      shreg       <= shreg_next;
      rx_data_out <= data_next;
    end
  end

  // Next-state logic: half-bit start validation, then one sample per bit period.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = bit_idx;
    shreg_next = shreg;
    data_next  = rx_data_out;
    unique case (state)
      RX_IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (!rx_sync) state_next = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_next   = '0;
          state_next = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          shreg_next = {rx_sync, shreg[DATA_WIDTH-1:1]};
          if (bit_idx == IDX_LAST) begin
            idx_next   = '0;
            state_next = RX_STOP;
          end else begin
            idx_next = bit_idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          if (rx_sync) data_next = shreg;
          state_next = RX_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: start bit, DATA_WIDTH bits LSB first, stop bit, then a
// one-cycle done pulse. The byte is latched on the accepting cycle only.
`timescale 1ns/1ps
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  output logic                  tx,
  output logic                  tx_active,
  output logic                  done_tx
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB) + 1;
  localparam int BW  = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_WIDTH - 1);

  tx_state_t             state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [BW-1:0]         bit_idx, idx_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic                  tx_next, active_next, done_next;

  // State and registered outputs; reset forces the line idle and drops any frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= TX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      tx_active <= 1'b0;
      done_tx   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= idx_next;
      shreg     <= shreg_next;
      tx        <= tx_next;
      tx_active <= active_next;
      done_tx   <= done_next;
    end
  end

  // Next-state logic; the line level for the upcoming bit is set on the transition into it.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    idx_next    = bit_idx;
    shreg_next  = shreg;
    tx_next     = tx;
    active_next = tx_active;
    done_next   = 1'b0;
    unique case (state)
      TX_IDLE: begin
        tx_next     = 1'b1;
        active_next = 1'b0;
        if (start) begin
          shreg_next  = tx_data_in;
          cnt_next    = '0;
          idx_next    = '0;
          tx_next     = 1'b0;
          active_next = 1'b1;
          state_next  = TX_START;
        end
      end
      TX_START: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          tx_next    = shreg[0];
          shreg_next = shreg >> 1;
          state_next = TX_DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (bit_idx == IDX_LAST) begin
            idx_next   = '0;
            tx_next    = 1'b1;
            state_next = TX_STOP;
          end else begin
            idx_next   = bit_idx + 1'b1;
            tx_next    = shreg[0];
            shreg_next = shreg >> 1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next    = '0;
          active_next = 1'b0;
          done_next   = 1'b1;
          state_next  = TX_DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      TX_DONE: begin
        state_next = TX_IDLE;
      end
      default: begin
        state_next = TX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART top: independent transmitter and receiver sharing one divider setting.
`timescale 1ns/1ps
module uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  output logic                  tx,
  output logic                  tx_active,
  output logic                  done_tx,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data_out
);

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tx_data_in(tx_data_in),
    .tx        (tx),
    .tx_active (tx_active),
    .done_tx   (done_tx)
  );

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data_out(rx_data_out)
  );

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for the UART with a short bit period (20 clocks) to keep runs small.
`timescale 1ns/1ps
module tb_uart;

  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUD_RATE  = 2_500_000;
  localparam int DATA_WIDTH = 8;
  localparam int CPB        = CLK_FREQ / BAUD_RATE;
  localparam int FRAME_BITS = DATA_WIDTH + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       tx, tx_active, done_tx;
  logic       rx;
  logic [7:0] rx_data_out;
  logic       loopback = 1'b1;
  logic       rx_man = 1'b1;

  assign rx = loopback ? tx : rx_man;

  always #10 clk = ~clk;

  uart #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tx_data_in (tx_data_in),
    .tx         (tx),
    .tx_active  (tx_active),
    .done_tx    (done_tx),
    .rx         (rx),
    .rx_data_out(rx_data_out)
  );

  int         checks = 0;
  int         errors = 0;
  int         done_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_rx = 8'h00;
  logic [7:0] exp_b;
  logic       prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: bit k of the 10-bit 8N1 frame for byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == FRAME_BITS - 1) return 1'b1;
    return b[k-1];
  endfunction

  // Scoreboard monitor: every done pulse consumes one expected byte.
  always @(negedge clk) begin
    if (rst && done_tx) begin
      done_count++;
      check("done_pulse_width", {31'd0, prev_done}, 32'd0);
      check("done_tx_active", {31'd0, tx_active}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done_tx with no byte pending, expected none");
      end else begin
        exp_b = exp_q.pop_front();
        check("rx_loopback", {24'd0, rx_data_out}, {24'd0, exp_b});
        model_rx = exp_b;
      end
    end
    prev_done = rst && done_tx;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while ((tx_active || done_tx) && n < 12 * CPB) begin
      @(negedge clk);
      n++;
    end
    if (tx_active || done_tx) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tx still busy after %0d cycles, expected idle", n);
      return;
    end
    start      = 1'b1;
    tx_data_in = b;
    exp_q.push_back(b);
    @(negedge clk);
    start      = 1'b0;
    tx_data_in = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_count < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", done_count, target);
    end
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
    for (int k = 0; k < FRAME_BITS; k++) begin
      rx_man = (k == FRAME_BITS - 1) ? stop_bit : frame_bit(b, k);
      repeat (CPB) @(negedge clk);
    end
    rx_man = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int match;
    int active_cnt;
    logic [7:0] bytes[10];

    // Reset values while held in reset.
    #100;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_tx_active", {31'd0, tx_active}, 32'd0);
    check("reset_done_tx", {31'd0, done_tx}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Waveform of 0x01: each frame bit held for exactly CPB clocks.
    send_byte(8'h01);
    active_cnt = 0;
    for (int k = 0; k < FRAME_BITS; k++) begin
      match = 0;
      for (int c = 0; c < CPB; c++) begin
        if (k > 0 || c > 0) @(negedge clk);
        if (tx === frame_bit(8'h01, k)) match++;
        if (tx_active === 1'b1) active_cnt++;
      end
      check($sformatf("wave_bit%0d_cycles", k), match, CPB);
    end
    check("wave_active_cycles", active_cnt, FRAME_BITS * CPB);
    @(negedge clk);
    check("wave_done_pulse", {31'd0, done_tx}, 32'd1);
    wait_done(1, 4);

    // Loopback of 0xA5.
    send_byte(8'hA5);
    wait_done(2, 12 * CPB);

    // Ten back-to-back random bytes including both extremes.
    for (int i = 0; i < 10; i++)
      bytes[i] = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom_range(0, 255));
    base = done_count;
    for (int i = 0; i < 10; i++) send_byte(bytes[i]);
    wait_done(base + 10, 12 * CPB);

    // Start pulsed mid-frame with other data must be ignored.
    base = done_count;
    send_byte(8'h5A);
    repeat (3 * CPB) @(negedge clk);
    start      = 1'b1;
    tx_data_in = 8'hC3;
    @(negedge clk);
    start      = 1'b0;
    wait_done(base + 1, 12 * CPB);
    repeat (3 * CPB) @(negedge clk);
    check("ignored_start_done_count", done_count - base, 1);
    check("ignored_start_idle", {31'd0, tx_active}, 32'd0);

    // Short low glitch on rx must not start a reception.
    @(negedge clk);
    loopback = 1'b0;
    rx_man   = 1'b0;
    repeat (5) @(negedge clk);
    rx_man = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_hold", {24'd0, rx_data_out}, {24'd0, model_rx});

    // Framing error: stop bit low, byte discarded.
    drive_rx_frame(8'h96, 1'b0);
    check("framing_error_hold", {24'd0, rx_data_out}, {24'd0, model_rx});

    // A correctly framed external byte is accepted.
    drive_rx_frame(8'h69, 1'b1);
    check("rx_external_byte", {24'd0, rx_data_out}, 32'h69);
    model_rx = 8'h69;
    loopback = 1'b1;

    // Reset mid-frame aborts immediately with no done pulse.
    base = done_count;
    send_byte(8'h77);
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_tx_active", {31'd0, tx_active}, 32'd0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("midreset_no_done", done_count - base, 0);
    send_byte(8'h3C);
    wait_done(base + 1, 12 * CPB);
    repeat (2) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
